// File: rtl/accel_led_meter.sv
// rtl/accel_led_meter.sv - windowed average of accelerometer samples driving a debounced 8-LED position meter with stale-link detection
module accel_led_meter #(
    parameter int          AVG_LOG2 = 3,
    parameter logic [31:0] TIMEOUT  = 32'd1200000
) (
    input  logic        clk_in,
    input  logic        nrst,
    input  logic [15:0] sample,
    input  logic        sample_valid,
    output logic [15:0] avg_out,
    output logic        avg_valid,
    output logic [7:0]  led_out,
    output logic        stale
);

    localparam int AW = 16 + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'((1 << AVG_LOG2) - 1);

    typedef enum logic {ST_ACCUM, ST_STALE} state_t;

    state_t               state_q;
    logic signed [AW-1:0] acc_q;
    logic [CW-1:0]        cnt_q;
    logic [31:0]          timer_q;
    logic [2:0]           shown_q;
    logic [2:0]           cand_idx_q;
    logic                 cand_valid_q;

    logic signed [AW-1:0] sum_d;
    logic                 win_done;
    logic [15:0]          avg_d;
    logic [2:0]           new_idx;
    logic [2:0]           shown_d;
    logic [2:0]           cand_idx_d;
    logic                 cand_valid_d;

    function automatic logic [7:0] onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

    // acc and cnt are always zero in STALE, so the returning sample naturally starts a fresh window
    always_comb begin
        sum_d        = acc_q + AW'($signed(sample));
        win_done     = sample_valid && (cnt_q == CNT_MAX);
        avg_d        = sum_d[AVG_LOG2 +: 16];
        new_idx      = {~avg_d[15], avg_d[14:13]};
        shown_d      = shown_q;
        cand_idx_d   = cand_idx_q;
        cand_valid_d = cand_valid_q;
        if (new_idx == shown_q) begin
            cand_valid_d = 1'b0;
        end else if (cand_valid_q && (new_idx == cand_idx_q)) begin
            shown_d      = new_idx;
            cand_valid_d = 1'b0;
        end else begin
            cand_idx_d   = new_idx;
            cand_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!nrst) begin
            state_q      <= ST_ACCUM;
            acc_q        <= '0;
            cnt_q        <= '0;
            timer_q      <= '0;
            shown_q      <= 3'd4;
            cand_idx_q   <= 3'd0;
            cand_valid_q <= 1'b0;
            avg_out      <= '0;
            avg_valid    <= 1'b0;
            led_out      <= 8'h10;
            stale        <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (sample_valid) begin
                state_q <= ST_ACCUM;
                stale   <= 1'b0;
                timer_q <= '0;
                if (win_done) begin
                    acc_q        <= '0;
                    cnt_q        <= '0;
                    avg_out      <= avg_d;
                    avg_valid    <= 1'b1;
                    shown_q      <= shown_d;
                    cand_idx_q   <= cand_idx_d;
                    cand_valid_q <= cand_valid_d;
                    led_out      <= onehot(shown_d);
                end else begin
                    acc_q   <= sum_d;
                    cnt_q   <= cnt_q + CW'(1);
                    led_out <= onehot(shown_q);
                end
            end else if (state_q == ST_ACCUM) begin
                if (timer_q == TIMEOUT - 32'd1) begin
                    state_q      <= ST_STALE;
                    stale        <= 1'b1;
                    led_out      <= 8'h81;
                    acc_q        <= '0;
                    cnt_q        <= '0;
                    cand_valid_q <= 1'b0;
                end else begin
                    timer_q <= timer_q + 32'd1;
                end
            end
        end
    end

endmodule

// File: doc/accel_led_meter.md
Name: accel_led_meter

Overview:
- Consumer stage directly downstream of the accelerometer sequencer/SPI path.
- Takes one signed 16-bit axis sample per completed SPI read and averages over a window of 2^AVG_LOG2 samples.
- Maps the average to a single-lit 8-LED position indicator, with two-window debounce.
- Flags a stale sensor link when samples stop arriving.

Parameters:
- AVG_LOG2, 3, log2 of the averaging window length; supported range 0..6.
- TIMEOUT, 32'd1200000, idle clk_in cycles without sample_valid before the stale state (100 ms at 12 MHz).

Ports:
- clk_in  input  1  system clock (12 MHz).
- nrst  input  1  reset; synchronous, active-low.
- sample  input  16  signed two's-complement axis sample (OUT_H:OUT_L as assembled from SPI MISO).
- sample_valid  input  1  one-cycle strobe; sample is valid this cycle. No backpressure: always accepted.
- avg_out  output  16  last completed window average, signed.
- avg_valid  output  1  one-cycle pulse; avg_out and led_out updated this cycle.
- led_out  output  8  position indicator, or error pattern when stale.
- stale  output  1  high while in the STALE state.

Behaviour:
- Reset (nrst=0 at a clk_in edge):
  - avg_out=0, avg_valid=0, stale=0, led_out=8'h10 (index 4, average 0).
  - Internal: acc=0, cnt=0, shown_idx=4, cand_valid=0, idle timer=0, state=ACCUM.
  - Reset mid-window discards all partial state.
- Accumulator:
  - Signed, 16+AVG_LOG2 bits; each accepted sample is sign-extended and added. Overflow is impossible by construction.
  - cnt counts 0..2^AVG_LOG2-1.
- Window completion: sample_valid with cnt = 2^AVG_LOG2-1. On that clock edge:
  - avg_out <= (acc+sample) >>> AVG_LOG2 (arithmetic shift, rounds toward -inf).
  - avg_valid <= 1 for exactly one cycle.
  - acc <= 0, cnt <= 0.
  - Latency: avg_valid is high in the cycle after the final sample strobe.
  - With AVG_LOG2=0, every sample completes a window and avg_out = sample.
- Index mapping: new_idx = {~avg[15], avg[14:13]} (offset-binary top 3 bits). -32768 maps to 0, 0 maps to 4, 32767 maps to 7.
- Debounce, evaluated at window completion:
  - new_idx == shown_idx: cand_valid <= 0.
  - cand_valid and new_idx == cand_idx: shown_idx <= new_idx, cand_valid <= 0.
  - Otherwise: cand_idx <= new_idx, cand_valid <= 1.
  - led_out <= one-hot(shown_idx as updated), registered on the same edge as avg_valid.
- FSM, two states:
  - ACCUM:
    - Idle timer increments each cycle without sample_valid and clears on sample_valid.
    - When the timer reaches TIMEOUT-1 with no sample this cycle, the next edge moves to STALE: stale <= 1, led_out <= 8'h81, acc <= 0, cnt <= 0, cand_valid <= 0.
    - shown_idx and avg_out are retained.
  - STALE:
    - Timer holds. No avg_valid.
    - On sample_valid, return to ACCUM: stale <= 0, led_out <= one-hot(shown_idx), timer <= 0.
    - That sample is accumulated as sample 0 of a fresh window. If AVG_LOG2=0 it also completes the window.
- Simultaneous events: sample_valid in the same cycle the timer would expire means the sample wins; no stale entry.
- Timer width is 32 bits. TIMEOUT=0 is illegal.

Test Plan:
- Reset: hold nrst=0 for 2 cycles -> led_out=8'h10, avg_out=0, avg_valid=0, stale=0.
- Debounce: 8 samples of 16'h7000 -> first avg_valid with avg_out=16'h7000 while led_out stays 8'h10; 8 more samples of 16'h7000 -> avg_valid with led_out=8'h80.
- Signed rounding: 4 samples of -3 then 4 samples of +2 (sum -4) -> avg_out=16'hFFFF, new_idx=3 held as candidate, led_out unchanged; an identical window follows -> led_out=8'h08.
- Timeout (TIMEOUT=100): after a window, 100 idle cycles -> stale=1 and led_out=8'h81 exactly on the 100th idle edge. Next sample_valid -> stale=0 and previous LED restored on the following cycle.
- Partial window dropped: 5 samples of 16'h4000, then timeout, then 8 samples of 0 -> avg_out=0, not a blend.
- Boundary: sample_valid on the cycle the timer would expire -> stale stays 0. Pulling nrst low after 3 samples of a window -> outputs return to reset values, and the next 8 samples of 16'h8000 yield avg_out=16'h8000.
